cache_plru: RTL and testbench
=============================

# cache_plru

- Parametrised tree pseudo-LRU replacement tracker for the L1 and L2 caches; supports any power-of-two associativity.
- Keeps `NUM_WAYS-1` tree bits per set and returns the least-recently-used way one cycle after an access.
- Accepts a most-recently-used (MRU) update for the accessed set.
- Adds three things: a post-reset initialisation sweep of the state array, a read-enable that holds its result, and optional same-set write-to-read forwarding.

## Interface
Parameters:
- `NUM_SETS`, 32, number of sets.
- `SET_INDEX_WIDTH`, 5, equals log2(`NUM_SETS`).
- `NUM_WAYS`, 4, associativity; a power of two, 2 to 16.
- `WAY_INDEX_WIDTH`, 2, equals log2(`NUM_WAYS`).

Ports:
- `clk` in 1: sole clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `access_i` in 1: read-enable; sample `set_i` this cycle.
- `set_i` in `SET_INDEX_WIDTH`: set to look up.
- `update_mru` in 1: mark `new_mru_way` as MRU in the latched set.
- `new_mru_way` in `WAY_INDEX_WIDTH`: way just used.
- `lru_way_o` out `WAY_INDEX_WIDTH`: LRU way of the latched set.
- `init_done_o` out 1: high once the array sweep has completed.

## Operation
- **Tree layout:** heap-ordered, `NUM_WAYS-1` bits; root is node 0; node i has children 2i+1 (left) and 2i+2 (right).
- **Node bit meaning:** 0 means the LRU is in the left subtree; 1 means the right subtree.
- **Lookup:** walk from the root, following the bits. The leaf reached is `lru_way_o`.
- **Update for way w:**
  - At depth d the path direction is `w[WAY_INDEX_WIDTH-1-d]`.
  - Each node on the path is written with the inverse of that direction.
  - Nodes off the path keep their value.
- **State after reset:**
  - FSM enters INIT; an init counter starts at 0.
  - `init_done_o`=0; `lru_way_o`=0.
  - Latched set = 0; latched bits = all zero.
- **INIT state:**
  - Writes all-zero bits to set `counter` each cycle, then increments the counter.
  - After set `NUM_SETS-1` is written, moves to READY and sets `init_done_o`=1.
  - Sweep takes exactly `NUM_SETS` cycles.
  - `access_i` and `update_mru` are ignored throughout INIT.
- **READY state, `access_i`=1:** array read of `set_i`; `set_i` is latched.
- **READY state, `access_i`=0:**
  - Latched set and latched bits hold.
  - `lru_way_o` stays stable indefinitely.
- **`update_mru`=1:**
  - Target is the latched set, i.e. the most recent `access_i`.
  - New bits = update(current latched bits, `new_mru_way`).
  - Written to the array at the edge.
- **`reset` mid-sweep or mid-operation:** restarts INIT from set 0. Prior array contents are discarded by the sweep.
- **`access_i` and `update_mru` in the same cycle:** both are performed. The write targets the old latched set; the read targets the new `set_i`.

## Timing
- **Lookup latency:** `access_i` in cycle N gives a valid `lru_way_o` in cycle N+1. The output is combinational from the latched/forwarded bits.
- **Update timing:** `update_mru` is valid from cycle N+1 onward for the set accessed in N. It is written at the end of that cycle.
- **Throughput:** one access plus one update per cycle.
- **`init_done_o` rise:** goes high `NUM_SETS` cycles after the first cycle with `reset` deasserted.
- **Same-set hazard:** an update to set S in cycle K, followed by (or concurrent with) an `access_i` of S in cycle K, makes the array read stale. Handling is described under Configuration.

## Configuration
- **Macro:** `CACHE_PLRU_BYPASS_EN`.
- **Defined:** write data is forwarded.
  - If an update writes set S while `access_i` reads S in the same cycle, the latched bits take the new bits rather than the array output.
  - If an update writes the latched set while `access_i`=0, the held latched bits are also replaced by the new bits.
  - Result: back-to-back updates to one set compose correctly.
- **Undefined:** no forwarding.
  - The same-set read returns the pre-write bits; the held bits are not refreshed.
  - A second consecutive update to the same set overwrites the first.
  - Callers must insert a one-cycle gap between same-set accesses.

## Test plan
- **Sweep/reset:** `NUM_SETS`=32, release reset → `init_done_o` low for 32 cycles then high. Accesses issued during the sweep have no effect. Afterwards every set reports `lru_way_o`=0.
- **4-way basic:**
  - Access set 3 → `lru_way_o`=0.
  - `update_mru` way 0 → bits {n0=1, n1=1, n2=0}.
  - Access set 3 again → `lru_way_o`=2.
  - `update_mru` way 2, then access set 3 → `lru_way_o`=1.
- **Hold:** access set 5, then hold `access_i`=0 for 10 cycles while `set_i` toggles → `lru_way_o` constant.
- **8-way fill:** `NUM_WAYS`=8; access and update ways 0 to 7 in order on set 0, with gaps between operations → final `lru_way_o`=0.
- **Bypass:**
  - Access set 7 on consecutive cycles with updates to way 0 then way 2.
  - Macro defined → next lookup returns 1.
  - Macro undefined → next lookup returns 0 (the way-0 update is lost).
- **Reset mid-sweep:** assert `reset` at sweep cycle 10 → `init_done_o` low and the sweep restarts at set 0. It takes a full 32 cycles; sets written earlier read as 0.

Source files
------------

// File: rtl/cache_plru_if.sv
// Access/update bus of the tree pseudo-LRU tracker.
// Carries lookup requests, MRU updates, the LRU result and the FSM debug state.
interface cache_plru_if #(
  parameter int SET_INDEX_WIDTH = 5,
  parameter int WAY_INDEX_WIDTH = 2
);
  // Handshake: the tracker has no back-pressure. access_i=1 in READY samples set_i
  // this cycle and lru_way_o is valid from the next cycle. update_mru=1 in READY
  // writes the latched set at the edge. Both are ignored while init_done_o=0.
  logic                       access_i;
  logic [SET_INDEX_WIDTH-1:0] set_i;
  logic                       update_mru;
  logic [WAY_INDEX_WIDTH-1:0] new_mru_way;
  logic [WAY_INDEX_WIDTH-1:0] lru_way_o;
  logic                       init_done_o;
  logic                       state_dbg;

  modport master (
    output access_i, set_i, update_mru, new_mru_way,
    input  lru_way_o, init_done_o, state_dbg
  );

  modport slave (
    input  access_i, set_i, update_mru, new_mru_way,
    output lru_way_o, init_done_o, state_dbg
  );
endinterface

// File: rtl/cache_plru.sv
// Tree pseudo-LRU tracker: NUM_WAYS-1 heap-ordered bits per set, post-reset array sweep.
// Optional same-set write-to-read forwarding is enabled by defining CACHE_PLRU_BYPASS_EN.
module cache_plru #(
  parameter int NUM_SETS        = 32,
  parameter int SET_INDEX_WIDTH = 5,
  parameter int NUM_WAYS        = 4,
  parameter int WAY_INDEX_WIDTH = 2
) (
  input logic        clk,
  input logic        reset,
  cache_plru_if.slave bus
);
  localparam int TREE_W = NUM_WAYS - 1;

  typedef logic [TREE_W-1:0] tree_t;
  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t                     state;
  logic [SET_INDEX_WIDTH-1:0] init_cnt;
  logic                       init_done;
  logic [SET_INDEX_WIDTH-1:0] latched_set;
  tree_t                      latched_bits;
  tree_t                      mem [NUM_SETS];

  tree_t rd_bits;
  tree_t new_bits;
  tree_t latch_next;
  logic  rd_fire;
  logic  upd_fire;

  // Walk from the root; each bit names the subtree holding the LRU leaf.
  function automatic logic [WAY_INDEX_WIDTH-1:0] tree_lookup(input tree_t bits);
    logic [WAY_INDEX_WIDTH-1:0] way;
    logic                       b;
    int                         node;
    way  = '0;
    node = 0;
    for (int d = 0; d < WAY_INDEX_WIDTH; d++) begin
      b = 1'b0;
      for (int k = 0; k < TREE_W; k++) begin
        if (k == node) b = bits[k];
      end
      way[WAY_INDEX_WIDTH-1-d] = b;
      node = 2 * node + 1 + int'(b);
    end
    return way;
  endfunction

  // Point every node on the path to way w away from w; off-path nodes keep their value.
  function automatic tree_t tree_update(input tree_t bits,
                                        input logic [WAY_INDEX_WIDTH-1:0] w);
    tree_t res;
    logic  dir;
    int    node;
    res  = bits;
    node = 0;
    for (int d = 0; d < WAY_INDEX_WIDTH; d++) begin
      dir = w[WAY_INDEX_WIDTH-1-d];
      for (int k = 0; k < TREE_W; k++) begin
        if (k == node) res[k] = ~dir;
      end
      node = 2 * node + 1 + int'(dir);
    end
    return res;
  endfunction

  assign rd_fire  = (state == ST_READY) && bus.access_i;
  assign upd_fire = (state == ST_READY) && bus.update_mru;
  assign rd_bits  = mem[bus.set_i];
  assign new_bits = tree_update(latched_bits, bus.new_mru_way);

  always_comb begin
    latch_next = latched_bits;
    if (rd_fire) latch_next = rd_bits;
`ifdef CACHE_PLRU_BYPASS_EN
    // A write to the set being read (or held) must be visible in the latched copy.
    if (upd_fire && (!rd_fire || (bus.set_i == latched_set))) latch_next = new_bits;
`else
    // Without forwarding the latched copy only ever comes from the array.
    latch_next = latch_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_INIT;
      init_cnt     <= '0;
      init_done    <= 1'b0;
      latched_set  <= '0;
      latched_bits <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == SET_INDEX_WIDTH'(NUM_SETS - 1)) begin
            state     <= ST_READY;
            init_done <= 1'b1;
          end
        end
        ST_READY: begin
          latched_bits <= latch_next;
          if (bus.access_i) latched_set <= bus.set_i;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Array writes: the sweep owns the array until READY, then MRU updates hit the latched set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_INIT) begin
        mem[init_cnt] <= '0;
      end else if (upd_fire) begin
        mem[latched_set] <= new_bits;
      end
    end
  end

  assign bus.lru_way_o   = tree_lookup(latched_bits);
  assign bus.init_done_o = init_done;
  assign bus.state_dbg   = state;
endmodule

// File: tb/tb_cache_plru.sv
// Directed bench for cache_plru: sweep/reset, 4-way lookups and updates, hold,
// 8-way fill and same-set forwarding (expectation follows CACHE_PLRU_BYPASS_EN).
module tb_cache_plru;
  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

`ifdef CACHE_PLRU_BYPASS_EN
  localparam int EXP_BYP = 1;
`else
  localparam int EXP_BYP = 0;
`endif

  always #5 clk = ~clk;

  cache_plru_if #(.SET_INDEX_WIDTH(5), .WAY_INDEX_WIDTH(2)) bus ();
  cache_plru_if #(.SET_INDEX_WIDTH(5), .WAY_INDEX_WIDTH(3)) bus8 ();

  cache_plru #(.NUM_SETS(32), .SET_INDEX_WIDTH(5), .NUM_WAYS(4), .WAY_INDEX_WIDTH(2)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  cache_plru #(.NUM_SETS(32), .SET_INDEX_WIDTH(5), .NUM_WAYS(8), .WAY_INDEX_WIDTH(3)) u_dut8 (
    .clk(clk), .reset(reset), .bus(bus8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.access_i     = 1'b0;
    bus.set_i        = '0;
    bus.update_mru   = 1'b0;
    bus.new_mru_way  = '0;
    bus8.access_i    = 1'b0;
    bus8.set_i       = '0;
    bus8.update_mru  = 1'b0;
    bus8.new_mru_way = '0;
  endtask

  task automatic access4(input int s);
    idle();
    bus.access_i = 1'b1;
    bus.set_i    = 5'(s);
    tick();
  endtask

  task automatic update4(input int w);
    idle();
    bus.update_mru  = 1'b1;
    bus.new_mru_way = 2'(w);
    tick();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_init_done", bus.init_done_o, 0);
    chk("rst_lru", bus.lru_way_o, 0);
    chk("rst_state", bus.state_dbg, 0);
    chk("rst_init_done8", bus8.init_done_o, 0);

    // Sweep with requests held active: they must be ignored.
    reset = 1'b0;
    bus.access_i    = 1'b1;
    bus.set_i       = 5'd3;
    bus.update_mru  = 1'b1;
    bus.new_mru_way = 2'd1;
    for (int i = 0; i < 31; i++) tick();
    chk("sweep_busy", bus.init_done_o, 0);
    chk("sweep_state", bus.state_dbg, 0);
    tick();
    chk("sweep_done", bus.init_done_o, 1);
    chk("sweep_state_ready", bus.state_dbg, 1);
    chk("sweep_done8", bus8.init_done_o, 1);
    chk("sweep_lru", bus.lru_way_o, 0);

    for (int s = 0; s < 32; s++) begin
      access4(s);
      chk($sformatf("post_sweep_set%0d", s), bus.lru_way_o, 0);
    end

    // 4-way basic
    access4(3);
    chk("basic_first", bus.lru_way_o, 0);
    update4(0);
    idle(); tick();
    access4(3);
    chk("basic_after_w0", bus.lru_way_o, 2);
    update4(2);
    idle(); tick();
    access4(3);
    chk("basic_after_w2", bus.lru_way_o, 1);

    // Hold with set_i toggling
    access4(5);
    update4(1);
    idle(); tick();
    access4(5);
    chk("hold_start", bus.lru_way_o, 2);
    idle();
    for (int i = 0; i < 10; i++) begin
      bus.set_i = 5'($urandom_range(0, 31));
      tick();
      chk("hold", bus.lru_way_o, 2);
    end

    // Back-to-back same-set updates
    access4(7);
    chk("byp_first", bus.lru_way_o, 0);
    idle();
    bus.access_i = 1'b1; bus.set_i = 5'd7; bus.update_mru = 1'b1; bus.new_mru_way = 2'd0;
    tick();
    bus.new_mru_way = 2'd2;
    tick();
    access4(7);
    chk("byp_result", bus.lru_way_o, EXP_BYP);

    // 8-way fill on set 0
    for (int w = 0; w < 8; w++) begin
      idle();
      bus8.access_i = 1'b1;
      tick();
      if (w == 0) chk("fill8_w0", bus8.lru_way_o, 0);
      if (w == 1) chk("fill8_w1", bus8.lru_way_o, 4);
      idle();
      bus8.update_mru  = 1'b1;
      bus8.new_mru_way = 3'(w);
      tick();
      idle();
      tick();
    end
    bus8.access_i = 1'b1;
    tick();
    chk("fill8_final", bus8.lru_way_o, 0);
    idle();

    // Reset mid-sweep
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_sweep_state", bus.state_dbg, 0);
    reset = 1'b1;
    tick();
    chk("mid_rst_init_done", bus.init_done_o, 0);
    reset = 1'b0;
    for (int i = 0; i < 31; i++) tick();
    chk("resweep_busy", bus.init_done_o, 0);
    tick();
    chk("resweep_done", bus.init_done_o, 1);
    access4(3);
    chk("resweep_set3", bus.lru_way_o, 0);
    access4(5);
    chk("resweep_set5", bus.lru_way_o, 0);
    access4(7);
    chk("resweep_set7", bus.lru_way_o, 0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
